// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state
// encodings, default width and the divide-by-zero LO pattern.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PREP = 2'b01,
        ST_CALC = 2'b10,
        ST_FIX  = 2'b11
    } md_state_e;

    localparam logic [MDU_WIDTH-1:0] MD_DIV0_LO = {MDU_WIDTH{1'b1}};

    function automatic logic op_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic op_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: shift-add multiply step or restoring
// divide step on a {high, low} accumulator pair.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_operand,
    input  logic               i_op_div,
    output logic [2*WIDTH-1:0] o_acc_next,
    output logic               o_q_bit
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_trial;
    logic           w_borrow;

    // Multiply adds the multiplicand on a set low bit and shifts right; divide
    // shifts the remainder left and keeps the trial subtraction if it did not borrow.
    always_comb begin
        w_sum      = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
                   + (i_acc[0] ? {1'b0, i_operand} : {(WIDTH+1){1'b0}});
        w_trial    = i_acc[2*WIDTH-1:WIDTH-1] - {1'b0, i_operand};
        w_borrow   = w_trial[WIDTH];
        o_acc_next = {2*WIDTH{1'b0}};
        o_q_bit    = 1'b0;
        if (i_op_div) begin
            o_q_bit = ~w_borrow;
            if (w_borrow) begin
                o_acc_next = {i_acc[2*WIDTH-2:0], 1'b0};
            end else begin
                o_acc_next = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_acc_next = {w_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit owning HI/LO; one bit per cycle.
// Optional MDU_EARLY_OUT_EN: multiplies with a zero operand skip CALC.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] md_a,
    input  logic [WIDTH-1:0] md_b,
    input  logic             md_cancel,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] mt_data,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] DIV0_LO  = {WIDTH{1'b1}};

    md_state_e          r_state;
    md_op_e             r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_mag_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed;
    logic               w_is_div;
    logic               w_early;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_step_acc;
    logic               w_q_bit;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .i_acc      (r_acc),
        .i_operand  (r_mag_b),
        .i_op_div   (w_is_div),
        .o_acc_next (w_step_acc),
        .o_q_bit    (w_q_bit)
    );

    // Operand magnitudes for PREP and sign-corrected results for FIX.
    always_comb begin
        w_signed = op_is_signed(r_op);
        w_is_div = op_is_div(r_op);
        w_mag_a  = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
        w_mag_b  = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;
`ifdef MDU_EARLY_OUT_EN
        w_early  = !w_is_div && ((r_a == {WIDTH{1'b0}}) || (r_b == {WIDTH{1'b0}}));
`else
        w_early  = 1'b0;
`endif
        w_prod   = r_neg_q ? -r_acc : r_acc;
        w_quot   = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        if (!w_is_div) begin
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod[WIDTH-1:0];
        end else if (r_b == {WIDTH{1'b0}}) begin
            w_fix_hi = r_a;
            w_fix_lo = DIV0_LO;
        end else begin
            w_fix_hi = w_rem;
            w_fix_lo = w_quot;
        end
    end

    // Control FSM, iteration datapath and architectural HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_op    <= MD_MULT;
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_mag_b <= {WIDTH{1'b0}};
            r_acc   <= {2*WIDTH{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= {WIDTH{1'b0}};
            r_lo    <= {WIDTH{1'b0}};
        end else begin
            r_done <= 1'b0;
            if (mthi_we) begin
                r_hi <= mt_data;
            end
            if (mtlo_we) begin
                r_lo <= mt_data;
            end
            if ((r_state != ST_IDLE) && md_cancel) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (md_start && !md_cancel) begin
                            r_op    <= md_op_e'(md_op);
                            r_a     <= md_a;
                            r_b     <= md_b;
                            r_busy  <= 1'b1;
                            r_state <= ST_PREP;
                        end
                    end
                    ST_PREP: begin
                        r_mag_b <= w_mag_b;
                        r_cnt   <= {CNT_W{1'b0}};
                        if (w_early) begin
                            r_acc   <= {2*WIDTH{1'b0}};
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= ST_FIX;
                        end else begin
                            r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
                            r_neg_q <= w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                            r_neg_r <= w_signed && r_a[WIDTH-1];
                            r_state <= ST_CALC;
                        end
                    end
                    ST_CALC: begin
                        // The quotient bit enters at the LSB vacated by the divide shift.
                        r_acc <= w_step_acc | {{(2*WIDTH-1){1'b0}}, w_q_bit};
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (r_cnt == CNT_LAST) begin
                            r_state <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        r_hi    <= w_fix_hi;
                        r_lo    <= w_fix_lo;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign md_busy = r_busy;
    assign md_done = r_done;
    assign hi      = r_hi;
    assign lo      = r_lo;

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the MIPS core; the execute-stage counterpart to the combinational ALU.
- Handles the MULT/MULTU/DIV/DIVU opcodes that the ALU does not implement.
- Accepts an operand pair from EX with a start handshake, iterates one bit per cycle, and writes the architectural HI/LO registers, which it owns.
- The pipeline stalls on md_busy; MFHI/MFLO read hi/lo directly.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets).
- md_start  in  1  start request; sampled only in IDLE.
- md_op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- md_a  in  WIDTH  rs operand (multiplicand / dividend).
- md_b  in  WIDTH  rt operand (multiplier / divisor).
- md_cancel  in  1  flush from exception or branch; aborts the operation in flight.
- mthi_we  in  1  MTHI write enable.
- mtlo_we  in  1  MTLO write enable.
- mt_data  in  WIDTH  MTHI/MTLO data.
- md_busy  out  1  high whenever the state is not IDLE.
- md_done  out  1  one-cycle pulse when HI/LO take a result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; hi=0; lo=0; md_busy=0; md_done=0; counter=0.
- FSM states: IDLE, PREP, CALC, FIX.
  - IDLE -> PREP when md_start=1 and md_cancel=0. op, md_a and md_b are latched at this edge; later input changes are ignored.
  - PREP (1 cycle): compute operand magnitudes for signed ops; record result signs. For DIV, the quotient sign is a^b and the remainder sign is a. Clear the accumulator; counter=0.
  - CALC (exactly WIDTH cycles): one step per cycle; counter increments; leave to FIX when counter==WIDTH-1.
    - Multiply: shift-add on a 2*WIDTH product.
    - Divide: restoring, one quotient bit per cycle.
  - FIX (1 cycle): apply two's-complement sign fix; write hi/lo at the exit edge; md_done=1 for the following cycle; state -> IDLE.
- Latency: with start sampled at edge E0, hi/lo are updated at edge E0+WIDTH+2, which is 34 for WIDTH=32. md_done is high for exactly the cycle after that edge. md_busy is high from E0 until that edge.
- Multiply results: hi = product[63:32], lo = product[31:0]. Signed and unsigned products are exact.
- Divide results: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- Divide corner cases:
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divisor zero, DIV or DIVU: hi=md_a (unmodified dividend), lo=0xFFFFFFFF. CALC still runs its full length.
- md_start while busy: ignored; no queueing.
- md_cancel in any non-IDLE state: state -> IDLE at the next edge; hi/lo unchanged; no md_done. md_cancel in IDLE blocks the start in the same cycle.
- MTHI/MTLO: accepted in any state and written at the edge. A completing FIX writes both hi and lo and overrides an MT write in the same cycle.
- mthi_we and mtlo_we may both be 1; both registers then take mt_data.
- Reset mid-operation aborts immediately; hi/lo return to 0.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: MULT/MULTU with md_a==0 or md_b==0 goes PREP -> FIX with the result forced to 0. hi=lo=0 at edge E0+2; md_done the cycle after. Divides are unaffected.
- Undefined: all operations take the full WIDTH+2 latency.

Decomposition:
- Shared package mdu_pkg holds:
  - md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU).
  - FSM state encodings (2 bits).
  - WIDTH default.
  - Divide-by-zero LO constant (all ones).
- One sub-module, mdu_step: combinational single-iteration datapath. Inputs: accumulator, operand, op class. Outputs: next accumulator and quotient bit.
- The FSM, counter, sign handling and HI/LO registers stay in mdu_iter.

Test Plan:
- MULT a=0xFFFFFFFD(-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; done exactly 34 cycles after start; busy high throughout.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9(-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/7 -> lo=0x0000000E, hi=0x00000002.
- Divide corner cases:
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU 5/0 -> hi=5, lo=0xFFFFFFFF.
- Abort and overlap cases:
  - Start MULT, assert md_cancel at cycle 10 -> IDLE next edge; hi/lo keep prior values; no done.
  - Second md_start during busy -> ignored.
  - mtlo_we=1 with mt_data=0x1234 in the FIX exit cycle -> lo holds the result, not 0x1234.
  - reset=0 mid-CALC -> hi=lo=0, busy=0 immediately.
